amf_window_ctrl: RTL
====================

// Module: amf_window_ctrl
// PURPOSE
//  Raster-scan controller for the approximate median compare network (cf).
//  - Accepts one 8-bit pixel per cycle over a valid/ready stream.
//  - Keeps two line buffers and a 3x3 window register.
//  - Emits each fully-interior 3x3 window as i0..i8, plus the network mode select s, with output backpressure.
//  - Sits between the pixel source and the cf instance; one window in, one filtered pixel out.
// PARAMETERS
//  IMG_W  640  pixels per line (>=3)
//  IMG_H  480  lines per frame (>=3)
//  PIX_W  8    pixel width; must match cf port width
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        pixel present
//  in_ready   out  1        pixel accepted when in_valid&&in_ready
//  in_pix     in   PIX_W    pixel, raster order
//  in_sof     in   1        marks first pixel of a frame
//  cfg_mode   in   2        network select, sampled at SOF; drives cf s
//  win_valid  out  1        window bus holds a valid window
//  win_ready  in   1        downstream consumed window
//  win_bus    out  9*PIX_W  i_k = win_bus[PIX_W*k +: PIX_W]; i0 top-left, i4 centre, i8 bottom-right, raster order
//  win_mode   out  2        mode latched for current frame
//  win_eof    out  1        qualifies last window of frame
//  sof_err    out  1        sticky: SOF seen mid-frame; cleared only by reset
// BEHAVIOUR
//  Reset values: all outputs 0 (in_ready 0 only while rst_n low); state IDLE; counters and buffers 0.
//  Handshake: in_ready = !win_valid || win_ready (single output stage, no bubbles).
//   - Window regs update only on an accepted pixel.
//   - win_valid holds, with win_bus stable, until win_ready.
//  States:
//   - IDLE->ACTIVE on accepted pixel with in_sof. That pixel is col0/row0 and latches cfg_mode into win_mode.
//   - ACTIVE->IDLE on accepting pixel (row IMG_H-1, col IMG_W-1).
//   - Pixels accepted in IDLE without in_sof are consumed and dropped (in_ready still follows the rule above).
//  Counters col 0..IMG_W-1 and row 0..IMG_H-1:
//   - col wraps to 0 with row+1.
//   - row wraps only through the IDLE return, never modulo.
//  Window emission:
//   - A window is produced when the accepted pixel has row>=2 && col>=2.
//   - Exactly (IMG_W-2)*(IMG_H-2) windows per frame.
//  Latency: win_valid asserts the cycle after the bottom-right pixel is accepted.
//  win_eof = 1 with the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
//  SOF mid-frame (ACTIVE):
//   - Set sof_err, restart counters with this pixel as (0,0), relatch mode.
//   - A pending output window is not dropped.
//  Line buffers hold rows r-1 and r-2; no initialisation between frames is needed, since the row>=2 rule masks stale data.
//  Reset mid-frame: everything returns to reset values; the next frame must begin with SOF.
// CONFIGURATION
//  AMF_STATS_EN defined:
//   - Adds ports stat_frames out 16 (frames completed, wraps at 2^16) and stat_wins out 24 (windows handed off in the current frame).
//   - stat_wins clears at SOF and increments on win_valid&&win_ready.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  amf_pkg:
//   - Constants MODE_Y17=2'b00, MODE_Y16=2'b01, MODE_Y15=2'b1x.
//   - State typedef {IDLE, ACTIVE}.
//   - PIX_W default.
//  Sub-module amf_line_buf: IMG_W-deep, PIX_W-wide shift delay with an enable. Instantiated twice, cascaded.
// TESTING (IMG_W=4, IMG_H=4 unless stated)
//  1. Pixels 0..15, SOF on 0, win_ready=1 -> 4 windows.
//     - First win_bus = {10,9,8,6,5,4,2,1,0} (i8..i0).
//     - Last = {15,14,13,11,10,9,7,6,5} with win_eof=1.
//  2. Same stream, win_ready toggled 1-of-3 cycles -> identical 4 windows in order; win_bus stable while stalled; in_ready=0 while stalled.
//  3. 3 junk pixels without SOF, then frame as in 1 -> junk dropped, output identical to 1.
//  4. cfg_mode=2 at SOF, changed to 0 mid-frame -> win_mode=2 for all 4 windows; next frame with cfg_mode=1 -> win_mode=1.
//  5. SOF reasserted at pixel 7 -> sof_err=1 sticky; windows restart from the new origin; 4 windows after the new SOF.
//  6. rst_n low for 1 cycle mid-frame, asynchronous to clk -> outputs 0 immediately; frame after reset reproduces test 1.
//     With AMF_STATS_EN: stat_frames=1, stat_wins=4.

Source files
------------

// File: rtl/amf_pkg.sv
// +----------------------------------------------------------------------------+
// | amf_pkg                                                                    |
// | Shared constants and types for the approximate-median window controller.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package amf_pkg;

   localparam int PIX_W_DEF = 8;

   // Compare-network selects carried on win_mode (bit 1 set means Y15).
   localparam logic [1:0] MODE_Y17 = 2'b00;
   localparam logic [1:0] MODE_Y16 = 2'b01;
   localparam logic [1:0] MODE_Y15 = 2'b1x;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/amf_line_buf.sv
// +----------------------------------------------------------------------------+
// | amf_line_buf                                                               |
// | DEPTH-stage enabled shift delay; dout_o is the sample taken DEPTH enables  |
// | earlier. Revision: 1.0                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module amf_line_buf #(
   parameter int DEPTH = 640,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [PIX_W-1:0] din_i,
   output logic [PIX_W-1:0] dout_o
);

   logic [PIX_W-1:0] taps_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps_q[i] <= '0;
         end
      end else if (en_i) begin
         taps_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign dout_o = taps_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/amf_window_ctrl.sv
// +----------------------------------------------------------------------------+
// | amf_window_ctrl                                                            |
// | Raster-scan 3x3 window generator feeding the approximate median network.  |
// | Optional AMF_STATS_EN adds frame/window statistic ports.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module amf_window_ctrl
   import amf_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PIX_W-1:0]   in_pix,
   input  logic               in_sof,
   input  logic [1:0]         cfg_mode,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [9*PIX_W-1:0] win_bus,
   output logic [1:0]         win_mode,
   output logic               win_eof,
   output logic               sof_err
`ifdef AMF_STATS_EN
   ,
   output logic [15:0]        stat_frames,
   output logic [23:0]        stat_wins
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   state_e           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic             win_valid_q;
   logic             win_eof_q;
   logic [1:0]       win_mode_q;
   logic             sof_err_q;
   logic [PIX_W-1:0] win_q [9];

   logic             w_accept;
   logic             w_take;
   logic             w_last;
   logic             w_emit;
   logic [CW-1:0]    w_cur_col;
   logic [RW-1:0]    w_cur_row;
   logic [PIX_W-1:0] w_lb1;
   logic [PIX_W-1:0] w_lb2;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_accept && in_sof) state_d = ACTIVE;
         ACTIVE:  if (w_take && w_last)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output / qualifier logic ----------------
   always_comb begin
      in_ready  = rst_n && (!win_valid_q || win_ready);
      w_accept  = in_valid && in_ready;
      // Pixels outside a frame are consumed but never enter the datapath.
      w_take    = w_accept && (in_sof || (state_q == ACTIVE));
      w_cur_col = in_sof ? '0 : col_q;
      w_cur_row = in_sof ? '0 : row_q;
      w_last    = (w_cur_row == RW'(IMG_H - 1)) && (w_cur_col == CW'(IMG_W - 1));
      w_emit    = w_take && (w_cur_row >= RW'(2)) && (w_cur_col >= CW'(2));
   end

   // Counters point at the position the next accepted pixel will occupy.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (w_take) begin
         if (w_last) begin
            col_d = '0;
            row_d = '0;
         end else if (w_cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = w_cur_row + RW'(1);
         end else begin
            col_d = w_cur_col + CW'(1);
            row_d = w_cur_row;
         end
      end
   end

   amf_line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (w_take),
      .din_i  (in_pix),
      .dout_o (w_lb1)
   );

   amf_line_buf #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (w_take),
      .din_i  (w_lb1),
      .dout_o (w_lb2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_eof_q   <= 1'b0;
         win_mode_q  <= '0;
         sof_err_q   <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (w_accept) begin
            win_valid_q <= w_emit;
            win_eof_q   <= w_emit && w_last;
         end else if (win_ready) begin
            win_valid_q <= 1'b0;
            win_eof_q   <= 1'b0;
         end
         if (w_accept && in_sof) begin
            win_mode_q <= cfg_mode;
         end
         if (w_accept && in_sof && (state_q == ACTIVE)) begin
            sof_err_q <= 1'b1;
         end
         // Window shifts left; new right column is (r-2, r-1, r) at this col.
         if (w_take) begin
            for (int k = 0; k < 3; k++) begin
               win_q[3*k]     <= win_q[3*k + 1];
               win_q[3*k + 1] <= win_q[3*k + 2];
            end
            win_q[2] <= w_lb2;
            win_q[5] <= w_lb1;
            win_q[8] <= in_pix;
         end
      end
   end

   for (genvar k = 0; k < 9; k++) begin : g_pack
      assign win_bus[PIX_W*k +: PIX_W] = win_q[k];
   end

   assign win_valid = win_valid_q;
   assign win_eof   = win_eof_q;
   assign win_mode  = win_mode_q;
   assign sof_err   = sof_err_q;

`ifdef AMF_STATS_EN
   logic [15:0] stat_frames_q;
   logic [23:0] stat_wins_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_frames_q <= '0;
         stat_wins_q   <= '0;
      end else begin
         if (w_take && w_last) begin
            stat_frames_q <= stat_frames_q + 16'd1;
         end
         if (w_accept && in_sof) begin
            stat_wins_q <= '0;
         end else if (win_valid_q && win_ready) begin
            stat_wins_q <= stat_wins_q + 24'd1;
         end
      end
   end

   assign stat_frames = stat_frames_q;
   assign stat_wins   = stat_wins_q;
`endif

endmodule

`default_nettype wire
